// File: rtl/arbiter_rr_burst.sv
// -----------------------------------------------------------------------------
// arbiter_rr_burst
//
// N-requester round-robin arbiter with per-grant transaction locking. A granted
// requester keeps the grant until it flags the last beat of its transaction
// (req & last) or abandons it (req low). The grant then moves at that same
// edge to the next requester in round-robin order, so there is no idle cycle
// between back-to-back transactions.
//
// Optional feature macro: ARB_WEIGHT_EN
//   When defined, a weight port is present. Requester g may win up to
//   max(weight[g],1) consecutive transactions before the pointer moves on.
//   When undefined, every requester behaves as if its weight were 1.
//
// Parameters:
//   N   number of requesters (2..16)
//   IW  width of gnt_id ($clog2(N))
//   WW  width of one weight field
//
// Ports:
//   clk     in   clock, rising edge
//   rst     in   asynchronous active-high reset
//   req     in   [N]     per-requester request, held until served
//   last    in   [N]     last beat flag, only looked at for the granted bit
//   weight  in   [N*WW]  requester i weight in [i*WW +: WW] (ARB_WEIGHT_EN)
//   gnt     out  [N]     registered one-hot grant, or all zero
//   gnt_id  out  [IW]    index of granted requester, held while gnt is zero
//   busy    out          registered copy of |gnt
// -----------------------------------------------------------------------------
module arbiter_rr_burst #(
    parameter int N  = 4,
    parameter int IW = $clog2(N),
    parameter int WW = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic [N-1:0]    last,
`ifdef ARB_WEIGHT_EN
    input  logic [N*WW-1:0] weight,
`endif
    output logic [N-1:0]    gnt,
    output logic [IW-1:0]   gnt_id,
    output logic            busy
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    // First set bit of mask scanning base, base+1, ... modulo N.
    function automatic logic [IW-1:0] pick_winner(input logic [N-1:0]  mask,
                                                  input logic [IW-1:0] base);
        logic [IW-1:0] res;
        logic          found;
        int            idx;
        res   = base;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            idx = int'(base) + i;
            if (idx >= N) begin
                idx = idx - N;
            end else begin
                idx = idx;
            end
            if (!found && mask[IW'(idx)]) begin
                res   = IW'(idx);
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return res;
    endfunction

    function automatic logic [N-1:0] onehot(input logic [IW-1:0] idx);
        logic [N-1:0] v;
        v      = {N{1'b0}};
        v[idx] = 1'b1;
        return v;
    endfunction

    // Successor index modulo N.
    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] idx);
        logic [IW-1:0] r;
        if (idx == IW'(N - 1)) begin
            r = {IW{1'b0}};
        end else begin
            r = idx + IW'(1);
        end
        return r;
    endfunction

    state_e        state_q,  state_d;
    logic [N-1:0]  gnt_q,    gnt_d;
    logic [IW-1:0] gnt_id_q, gnt_id_d;
    logic [IW-1:0] ptr_q,    ptr_d;
    logic          busy_q,   busy_d;

    logic [WW-1:0] cred_cur_s;   // credits used by current holder
    logic [WW-1:0] w_eff_s;      // effective weight of current holder

`ifdef ARB_WEIGHT_EN
    logic [WW-1:0] cred_q, cred_d;
    logic [WW-1:0] w_raw_s;

    assign cred_cur_s = cred_q;
    assign w_raw_s    = weight[gnt_id_q*WW +: WW];
    // A zero weight still entitles the holder to one transaction.
    assign w_eff_s    = (w_raw_s == {WW{1'b0}}) ? {{(WW-1){1'b0}}, 1'b1} : w_raw_s;
`else
    assign cred_cur_s = {WW{1'b0}};
    assign w_eff_s    = {{(WW-1){1'b0}}, 1'b1};
`endif

    logic          req_g_s;
    logic          last_g_s;
    logic          release_s;
    logic          stay_s;
    logic [IW-1:0] ptr_rel_s;
    logic [N-1:0]  mask_oth_s;
    logic [N-1:0]  mask_rel_s;
    logic [IW-1:0] win_rel_s;
    logic [IW-1:0] win_idle_s;

    assign req_g_s    = req[gnt_id_q];
    assign last_g_s   = last[gnt_id_q];
    assign release_s  = !req_g_s || last_g_s;
    // Holder keeps priority while it still requests and has credits left;
    // compared one bit wider so cred+1 cannot wrap.
    assign stay_s     = req_g_s &&
                        (({1'b0, cred_cur_s} + {{WW{1'b0}}, 1'b1}) < {1'b0, w_eff_s});
    assign ptr_rel_s  = stay_s ? gnt_id_q : next_idx(gnt_id_q);
    assign mask_oth_s = req & ~onehot(gnt_id_q);
    // Holder is excluded unless staying, or unless nobody else is asking,
    // in which case it is re-granted without a gap.
    assign mask_rel_s = stay_s                       ? req        :
                        (mask_oth_s != {N{1'b0}})    ? mask_oth_s : req;
    assign win_rel_s  = pick_winner(mask_rel_s, ptr_rel_s);
    assign win_idle_s = pick_winner(req, ptr_q);

    // Next-state, grant and pointer computation.
    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        gnt_id_d = gnt_id_q;
        ptr_d    = ptr_q;
`ifdef ARB_WEIGHT_EN
        cred_d   = cred_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req != {N{1'b0}}) begin
                    gnt_d    = onehot(win_idle_s);
                    gnt_id_d = win_idle_s;
                    state_d  = ST_GRANT;
`ifdef ARB_WEIGHT_EN
                    cred_d   = {WW{1'b0}};
`endif
                end else begin
                    gnt_d    = {N{1'b0}};
                    state_d  = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (release_s) begin
                    ptr_d = ptr_rel_s;
                    if (mask_rel_s != {N{1'b0}}) begin
                        gnt_d    = onehot(win_rel_s);
                        gnt_id_d = win_rel_s;
                        state_d  = ST_GRANT;
`ifdef ARB_WEIGHT_EN
                        if (win_rel_s == gnt_id_q) begin
                            cred_d = cred_q + {{(WW-1){1'b0}}, 1'b1};
                        end else begin
                            cred_d = {WW{1'b0}};
                        end
`endif
                    end else begin
                        gnt_d    = {N{1'b0}};
                        state_d  = ST_IDLE;
`ifdef ARB_WEIGHT_EN
                        cred_d   = {WW{1'b0}};
`endif
                    end
                end else begin
                    gnt_d   = gnt_q;
                    state_d = ST_GRANT;
                end
            end
            default: begin
                gnt_d   = {N{1'b0}};
                state_d = ST_IDLE;
            end
        endcase
        busy_d = |gnt_d;
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            gnt_q    <= {N{1'b0}};
            gnt_id_q <= {IW{1'b0}};
            ptr_q    <= {IW{1'b0}};
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            gnt_id_q <= gnt_id_d;
            ptr_q    <= ptr_d;
            busy_q   <= busy_d;
        end
    end

`ifdef ARB_WEIGHT_EN
    // Credit counter for consecutive wins of the current holder.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cred_q <= {WW{1'b0}};
        end else begin
            cred_q <= cred_d;
        end
    end
`endif

    assign gnt    = gnt_q;
    assign gnt_id = gnt_id_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_arbiter_rr_burst.sv
// -----------------------------------------------------------------------------
// tb_arbiter_rr_burst
//
// Directed bench for arbiter_rr_burst with N=4. Inputs are driven 1 time unit
// after the rising edge; outputs are checked 1 time unit after the edge that
// consumed them. The weighted scenario is compiled only with ARB_WEIGHT_EN.
// -----------------------------------------------------------------------------
module tb_arbiter_rr_burst;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  last;
`ifdef ARB_WEIGHT_EN
    logic [11:0] weight;
`endif
    logic [3:0]  gnt;
    logic [1:0]  gnt_id;
    logic        busy;

    int checks = 0;
    int errors = 0;

    arbiter_rr_burst #(.N(4), .IW(2), .WW(3)) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .last   (last),
`ifdef ARB_WEIGHT_EN
        .weight (weight),
`endif
        .gnt    (gnt),
        .gnt_id (gnt_id),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_g(input string tag, input logic [3:0] eg, input logic [1:0] eid);
        chk({tag, "_gnt"},  32'(gnt),    32'(eg));
        chk({tag, "_id"},   32'(gnt_id), 32'(eid));
        chk({tag, "_busy"}, 32'(busy),   32'(|eg));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] exp_rr_g  [8] = '{4'b0001, 4'b0010, 4'b0010, 4'b0100,
                                  4'b0100, 4'b1000, 4'b1000, 4'b0001};
    logic [1:0] exp_rr_id [8] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0};
`ifdef ARB_WEIGHT_EN
    logic [3:0] exp_w_g   [8] = '{4'b0001, 4'b1000, 4'b1000, 4'b1000,
                                  4'b0001, 4'b1000, 4'b1000, 4'b1000};
    logic [1:0] exp_w_id  [8] = '{2'd0, 2'd3, 2'd3, 2'd3, 2'd0, 2'd3, 2'd3, 2'd3};
`endif

    initial begin
        rst  = 1'b1;
        req  = 4'b0000;
        last = 4'b0000;
`ifdef ARB_WEIGHT_EN
        weight = {3'd1, 3'd1, 3'd1, 3'd1};
`endif
        // Reset values.
        repeat (2) @(posedge clk);
        #1;
        expect_g("reset", 4'b0000, 2'd0);
        rst = 1'b0;

        // No requests: stay idle.
        for (int i = 0; i < 5; i++) begin
            tick();
            expect_g("idle", 4'b0000, 2'd0);
        end

        // All request, 2-beat transactions, no bubbles.
        req = 4'b1111;
        last = 4'b0000;
        tick();
        expect_g("rr_first", 4'b0001, 2'd0);
        for (int k = 0; k < 8; k++) begin
            last = (k % 2 == 1) ? 4'b1111 : 4'b0000;
            tick();
            expect_g("rr_seq", exp_rr_g[k], exp_rr_id[k]);
        end
        req = 4'b0000;
        last = 4'b0000;
        tick();
        expect_g("rr_abandon", 4'b0000, 2'd0);

        // Lone requester with last every cycle keeps the grant.
        req = 4'b0100;
        last = 4'b1111;
        tick();
        expect_g("lone_first", 4'b0100, 2'd2);
        for (int i = 0; i < 4; i++) begin
            tick();
            expect_g("lone_hold", 4'b0100, 2'd2);
        end
        req = 4'b0000;
        last = 4'b0000;
        tick();
        expect_g("lone_drop", 4'b0000, 2'd2);

        // Grant to 1, abandoned in its 3rd cycle while 3 waits.
        req = 4'b0010;
        tick();
        expect_g("ab_c1", 4'b0010, 2'd1);
        req = 4'b1010;
        tick();
        expect_g("ab_c2", 4'b0010, 2'd1);
        tick();
        expect_g("ab_c3", 4'b0010, 2'd1);
        req = 4'b1000;
        tick();
        expect_g("ab_next", 4'b1000, 2'd3);
        req = 4'b0000;
        tick();
        expect_g("ab_idle", 4'b0000, 2'd3);

        // Requester 0 locked (last only on others), then hands over 1 -> 3.
        req = 4'b1011;
        last = 4'b1110;
        tick();
        expect_g("lock_first", 4'b0001, 2'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            expect_g("lock_hold", 4'b0001, 2'd0);
        end
        last = 4'b0001;
        tick();
        expect_g("lock_to1", 4'b0010, 2'd1);
        last = 4'b0010;
        tick();
        expect_g("lock_to3", 4'b1000, 2'd3);
        req = 4'b0000;
        last = 4'b0000;
        tick();
        expect_g("lock_idle", 4'b0000, 2'd3);

        // Asynchronous reset mid-grant, pointer returns to 0.
        req = 4'b0100;
        tick();
        expect_g("ar_g2", 4'b0100, 2'd2);
        req = 4'b0110;
        last = 4'b0100;
        tick();
        expect_g("ar_g1", 4'b0010, 2'd1);
        last = 4'b0000;
        #1;
        rst = 1'b1;
        #1;
        expect_g("ar_async", 4'b0000, 2'd0);
        #1;
        rst = 1'b0;
        req = 4'b1010;
        tick();
        expect_g("ar_ptr0", 4'b0010, 2'd1);
        req = 4'b0000;
        tick();
        expect_g("ar_idle", 4'b0000, 2'd1);

`ifdef ARB_WEIGHT_EN
        // Weighted: requester 3 wins three transactions in a row.
        rst = 1'b1;
        #1;
        rst = 1'b0;
        weight = {3'd3, 3'd1, 3'd1, 3'd1};
        req = 4'b1001;
        last = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            tick();
            expect_g("wt_seq", exp_w_g[k], exp_w_id[k]);
        end
        req = 4'b0000;
        last = 4'b0000;
        tick();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
